// File: rtl/usb_stream_demux.sv
// Valid/ready stream demultiplexer: routes each accepted word to a per-channel FIFO
// chosen by in_sel. Words with an out-of-range in_sel are dropped and counted.
module usb_stream_demux #(
  parameter int unsigned NUM_CH      = 2,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned DEPTH       = 2,
  parameter int unsigned NARROW_W    = 8,
  parameter logic [NUM_CH-1:0] NARROW_MASK = 2'b10,
  localparam int unsigned SEL_W      = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [DATA_W-1:0]        in_data,
  output logic [NUM_CH-1:0]        out_valid,
  input  logic [NUM_CH-1:0]        out_ready,
  output logic [NUM_CH*DATA_W-1:0] out_data,
  output logic                     sel_err,
  output logic [7:0]               drop_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [DATA_W-1:0] mem_q    [NUM_CH][DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q [NUM_CH];
  logic [PTR_W-1:0]  wr_ptr_d [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr_q [NUM_CH];
  logic [PTR_W-1:0]  rd_ptr_d [NUM_CH];
  logic [CNT_W-1:0]  cnt_q    [NUM_CH];
  logic [CNT_W-1:0]  cnt_d    [NUM_CH];

  logic [NUM_CH-1:0] full;
  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop;
  logic              sel_ok;
  logic              sel_full;
  logic              accept;
  logic [DATA_W-1:0] wdata;
  logic              sel_err_q, sel_err_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  // Input side: ready never looks at out_ready, so a full channel stays stalled
  // even in a cycle where its consumer pops.
  always_comb begin
    sel_ok   = (32'(in_sel) < NUM_CH);
    sel_full = 1'b0;
    full     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      full[i] = (cnt_q[i] == CNT_W'(DEPTH));
      if (in_sel == SEL_W'(i)) sel_full = full[i];
    end
    in_ready = !rst && (!sel_ok || !sel_full);
    accept   = in_valid && in_ready;
    wdata    = in_data;
    for (int i = 0; i < NUM_CH; i++) begin
      if (NARROW_MASK[i] && (in_sel == SEL_W'(i))) begin
        for (int b = NARROW_W; b < DATA_W; b++) wdata[b] = 1'b0;
      end
    end
  end

  always_comb begin
    push      = '0;
    pop       = '0;
    out_valid = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      push[i]      = accept && sel_ok && (in_sel == SEL_W'(i));
      out_valid[i] = (cnt_q[i] != '0);
      pop[i]       = out_valid[i] && out_ready[i];
      wr_ptr_d[i]  = wr_ptr_q[i] + PTR_W'(push[i]);
      rd_ptr_d[i]  = rd_ptr_q[i] + PTR_W'(pop[i]);
      cnt_d[i]     = cnt_q[i] + CNT_W'(push[i]) - CNT_W'(pop[i]);
    end
  end

  always_comb begin
    sel_err_d  = accept && !sel_ok;
    drop_cnt_d = drop_cnt_q;
    if (sel_err_d && (drop_cnt_q != 8'hFF)) drop_cnt_d = drop_cnt_q + 8'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
        cnt_q[i]    <= '0;
      end
      sel_err_q  <= 1'b0;
      drop_cnt_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
        cnt_q[i]    <= cnt_d[i];
      end
      sel_err_q  <= sel_err_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage needs no reset: out_data is gated by the count.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CH; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i]] <= wdata;
    end
  end

  always_comb begin
    out_data = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (cnt_q[i] != '0) out_data[i*DATA_W +: DATA_W] = mem_q[i][rd_ptr_q[i]];
    end
  end

  assign sel_err  = sel_err_q;
  assign drop_cnt = drop_cnt_q;

endmodule

// File: tb/tb_usb_stream_demux.sv
// Bench for usb_stream_demux: a 2-channel and a 3-channel instance, each checked every
// cycle against a queue-based model, plus directed literal expectations.
module tb_usb_stream_demux;

  localparam int DEPTH = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        iv    [2];
  logic [1:0]  isel  [2];
  logic [31:0] idata [2];
  logic [2:0]  ordy  [2];

  logic        ir2, se2, ir3, se3;
  logic [1:0]  ov2;
  logic [2:0]  ov3;
  logic [63:0] od2;
  logic [95:0] od3;
  logic [7:0]  dc2, dc3;

  usb_stream_demux dut2 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir2), .in_sel(isel[0][0]),
    .in_data(idata[0]), .out_valid(ov2), .out_ready(ordy[0][1:0]), .out_data(od2),
    .sel_err(se2), .drop_cnt(dc2)
  );

  usb_stream_demux #(.NUM_CH(3), .NARROW_MASK(3'b010)) dut3 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir3), .in_sel(isel[1]),
    .in_data(idata[1]), .out_valid(ov3), .out_ready(ordy[1]), .out_data(od3),
    .sel_err(se3), .drop_cnt(dc3)
  );

  logic [2:0]  ov_a [2];
  logic [31:0] od_a [2][3];
  logic        ir_a [2];
  logic        se_a [2];
  logic [7:0]  dc_a [2];

  always_comb begin
    ov_a[0] = {1'b0, ov2};
    ov_a[1] = ov3;
    od_a[0][0] = od2[31:0];
    od_a[0][1] = od2[63:32];
    od_a[0][2] = '0;
    for (int k = 0; k < 3; k++) od_a[1][k] = od3[k*32 +: 32];
    ir_a[0] = ir2; ir_a[1] = ir3;
    se_a[0] = se2; se_a[1] = se3;
    dc_a[0] = dc2; dc_a[1] = dc3;
  end

  int checks   = 0;
  int failures = 0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%h expected=%h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one word queue per channel, channel 1 is narrow in both instances.
  typedef logic [31:0] wq_t[$];
  wq_t  mq [6];
  int   exp_drop [2];
  logic exp_se   [2];
  logic m_acc;

  function automatic int nch(int d);
    return (d == 0) ? 2 : 3;
  endfunction

  function automatic logic model_ready(int d);
    if (rst) return 1'b0;
    if (int'(isel[d]) >= nch(d)) return 1'b1;
    return mq[d*3 + int'(isel[d])].size() < DEPTH;
  endfunction

  always @(posedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        for (int c = 0; c < 3; c++) mq[d*3 + c].delete();
        exp_drop[d] = 0;
        exp_se[d]   = 1'b0;
      end else begin
        m_acc = iv[d] && model_ready(d);
        for (int c = 0; c < nch(d); c++)
          if (mq[d*3 + c].size() > 0 && ordy[d][c]) void'(mq[d*3 + c].pop_front());
        exp_se[d] = 1'b0;
        if (m_acc) begin
          if (int'(isel[d]) < nch(d)) begin
            mq[d*3 + int'(isel[d])].push_back((isel[d] == 2'd1) ? (idata[d] & 32'h0000_00FF)
                                                                 : idata[d]);
          end else begin
            exp_se[d] = 1'b1;
            if (exp_drop[d] < 255) exp_drop[d]++;
          end
        end
      end
    end
  end

  logic chk_en = 1'b0;

  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        for (int c = 0; c < nch(d); c++) begin
          chk($sformatf("d%0d_ch%0d_valid", d, c), 32'(ov_a[d][c]), 32'(mq[d*3 + c].size() > 0));
          chk($sformatf("d%0d_ch%0d_data", d, c), od_a[d][c],
              (mq[d*3 + c].size() > 0) ? mq[d*3 + c][0] : 32'h0);
        end
        chk($sformatf("d%0d_in_ready", d), 32'(ir_a[d]), 32'(model_ready(d)));
        chk($sformatf("d%0d_sel_err", d), 32'(se_a[d]), 32'(exp_se[d]));
        chk($sformatf("d%0d_drop_cnt", d), 32'(dc_a[d]), 32'(exp_drop[d]));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push2(logic s, logic [31:0] dt);
    iv[0] = 1'b1; isel[0] = {1'b0, s}; idata[0] = dt;
    tick();
    iv[0] = 1'b0;
  endtask

  int   acc_cnt;
  int   cyc;
  logic took;

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      iv[d] = 1'b0; isel[d] = '0; idata[d] = '0; ordy[d] = '0;
    end
    ordy[1] = 3'b111;
    tick();
    chk_en = 1'b1;
    #1 chk("reset_in_ready", 32'(ir2), 32'h0);
    tick();
    rst = 1'b0;
    #1;
    chk("reset_out_valid", 32'(ov2), 32'h0);
    chk("reset_out_data_lo", od2[31:0], 32'h0);
    chk("reset_drop_cnt", 32'(dc3), 32'h0);

    // ch0 wide, ch1 narrow
    push2(1'b0, 32'hDEAD_BEEF);
    #1;
    chk("t1_out_valid", 32'(ov2), 32'h1);
    chk("t1_ch0_data", od2[31:0], 32'hDEAD_BEEF);
    chk("t1_ch1_data", od2[63:32], 32'h0);
    push2(1'b1, 32'hDEAD_BEEF);
    #1;
    chk("t2_ch1_data", od2[63:32], 32'h0000_00EF);
    chk("t2_ch0_data", od2[31:0], 32'hDEAD_BEEF);
    ordy[0] = 3'b011;
    tick();
    ordy[0] = 3'b000;

    // stalled ch0 must not block ch1
    push2(1'b0, 32'h1);
    push2(1'b0, 32'h2);
    isel[0] = 2'd0;
    #1 chk("t3_ready_sel0_full", 32'(ir2), 32'h0);
    isel[0] = 2'd1;
    #1 chk("t3_ready_sel1", 32'(ir2), 32'h1);
    push2(1'b1, 32'h55);
    #1 chk("t3_ch1_data", od2[63:32], 32'h55);
    ordy[0] = 3'b011;
    #1 chk("t3_pop_first", od2[31:0], 32'h1);
    tick();
    chk("t3_pop_second", od2[31:0], 32'h2);
    tick();
    chk("t3_ch0_empty", 32'(ov2[0]), 32'h0);
    ordy[0] = 3'b000;

    // full with simultaneous pop: no accept that cycle
    push2(1'b0, 32'hA);
    push2(1'b0, 32'hB);
    ordy[0] = 3'b001;
    iv[0] = 1'b1; isel[0] = 2'd0; idata[0] = 32'hC;
    #1 chk("t4_full_pop_ready", 32'(ir2), 32'h0);
    tick();
    chk("t4_freed_ready", 32'(ir2), 32'h1);
    tick();
    iv[0] = 1'b0;
    #1 chk("t4_accepted_data", od2[31:0], 32'hC);
    tick();

    // random traffic, held while stalled
    acc_cnt = 0; cyc = 0; took = 1'b1;
    while (acc_cnt < 100 && cyc < 3000) begin
      if (!iv[0] || took) begin
        iv[0]    = ($urandom_range(0, 3) != 0);
        isel[0]  = 2'($urandom_range(0, 1));
        idata[0] = $urandom;
      end
      ordy[0] = 3'($urandom_range(0, 3));
      #1;
      took = iv[0] && model_ready(0);
      if (took) acc_cnt++;
      tick();
      cyc++;
    end
    iv[0] = 1'b0;
    chk("t4_random_accepts", 32'(acc_cnt), 32'd100);
    ordy[0] = 3'b011;
    repeat (4) tick();
    chk("t4_drained", 32'(ov2), 32'h0);
    ordy[0] = 3'b000;

    // out-of-range selects on the 3-channel instance
    iv[1] = 1'b1; isel[1] = 2'd3; idata[1] = 32'h1234_5678;
    tick();
    iv[1] = 1'b0;
    #1;
    chk("t5_sel_err_pulse", 32'(se3), 32'h1);
    chk("t5_drop_cnt_one", 32'(dc3), 32'h1);
    chk("t5_no_valid", 32'(ov3), 32'h0);
    tick();
    chk("t5_sel_err_low", 32'(se3), 32'h0);
    iv[1] = 1'b1; isel[1] = 2'd2; idata[1] = 32'hCAFE_F00D;
    tick();
    isel[1] = 2'd1;
    tick();
    iv[1] = 1'b0;
    #1 chk("t5_ch1_narrow", od3[63:32], 32'h0000_000D);
    isel[1] = 2'd3; iv[1] = 1'b1;
    for (int k = 0; k < 300; k++) tick();
    iv[1] = 1'b0;
    #1 chk("t5_drop_cnt_sat", 32'(dc3), 32'd255);

    // reset with data in flight
    push2(1'b0, 32'h11);
    push2(1'b1, 32'h22);
    push2(1'b0, 32'h33);
    chk("t6_pre_reset_valid", 32'(ov2), 32'h3);
    rst = 1'b1;
    iv[0] = 1'b1; isel[0] = 2'd1; idata[0] = 32'h44;
    tick();
    rst = 1'b0; iv[0] = 1'b0;
    #1;
    chk("t6_out_valid", 32'(ov2), 32'h0);
    chk("t6_out_data", od2[63:32] | od2[31:0], 32'h0);
    chk("t6_drop_cnt", 32'(dc3), 32'h0);
    push2(1'b0, 32'h77);
    #1;
    chk("t6_first_push_valid", 32'(ov2), 32'h1);
    chk("t6_first_push_data", od2[31:0], 32'h77);
    tick();

    chk_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
